// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle for mod_n_updown_counter. The master drives the count
// controls. The slave (the counter) returns count, terminal count and the wrap flag.
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             En;
    logic             Up;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] count;
    logic             Tc;
    logic             Wrap;

    modport master (
        output En, Up, Load, LoadVal,
        input  count, Tc, Wrap
    );

    modport slave (
        input  En, Up, Load, LoadVal,
        output count, Tc, Wrap
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Synchronous modulo-N up/down counter with clamped parallel load, combinational Tc and registered Wrap.
// Optional build macro MOD_N_UPDOWN_COUNTER_SATURATE_EN: hold at the limits instead of wrapping.
module mod_n_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input logic                    Clk,
    input logic                    ClrN,
    mod_n_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
    localparam bit               FULL_RANGE = (MODULUS == (1 << WIDTH));

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_val_c;
    logic             at_top, at_bottom;

    // When every WIDTH-bit value is legal, no clamp is needed and no constant-false compare is built.
    generate
        if (FULL_RANGE) begin : g_no_clamp
            assign load_val_c = bus.LoadVal;
        end else begin : g_clamp
            assign load_val_c = (bus.LoadVal > MAX_VAL) ? MAX_VAL : bus.LoadVal;
        end
    endgenerate

    assign at_top    = (count_q == MAX_VAL);
    assign at_bottom = (count_q == '0);

    // NOTE: assign every always_comb output a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.Load) begin
            count_d = load_val_c;
        end else if (bus.En) begin
            if (bus.Up) begin
                if (at_top) begin
`ifdef MOD_N_UPDOWN_COUNTER_SATURATE_EN
                    count_d = MAX_VAL;
`else
                    count_d = '0;
`endif
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_bottom) begin
`ifdef MOD_N_UPDOWN_COUNTER_SATURATE_EN
                    count_d = '0;
`else
                    count_d = MAX_VAL;
`endif
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk) begin
        if (!ClrN) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Tc is left unregistered so a cascaded stage can step on the same edge.
    assign bus.Tc    = bus.En & ((bus.Up & at_top) | (~bus.Up & at_bottom));
    assign bus.count = count_q;
    assign bus.Wrap  = wrap_q;
endmodule
